iobus_seg_display: RTL and testbench

Memory-mapped 4-digit seven-segment display controller on the OTTER I/O bus. It decodes CPU writes for a 16-bit hex value and a control byte, then time-multiplexes the four Basys3 digits with an anti-ghosting gap between digits. It replaces software-driven segment/anode scanning: the MCU writes a value once and the block refreshes the display autonomously. Its read-back output feeds the wrapper's IOBUS_in mux.

---
 rtl/iobus_seg_display_if.sv | 9 +
 rtl/iobus_seg_display.sv | 105 ++++++++++
 tb/tb_iobus_seg_display.sv | 133 +++++++++++++
 3 files changed

// File: rtl/iobus_seg_display_if.sv
// iobus_seg_display_if: OTTER I/O bus slice seen by the seven-segment controller
interface iobus_seg_display_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_rd_data;
  modport master(output iobus_addr, iobus_out, iobus_wr, input iobus_rd_data);
  modport slave(input iobus_addr, iobus_out, iobus_wr, output iobus_rd_data);
endinterface

// File: rtl/iobus_seg_display.sv
// iobus_seg_display: memory-mapped 4-digit hex display scanner with anti-ghosting gap
module iobus_seg_display #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100C00C,
  parameter int          REFRESH_DIV = 25000,
  parameter int          GAP_CYCLES  = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  iobus_seg_display_if.slave        bus,
  output logic [7:0]                segs,
  output logic [3:0]                an
);
  typedef enum logic [1:0] {DISABLED, SHOW, GAP} state_t;
  localparam int CMAX = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction
  // {an, segs} for one digit slot; a blanked leading zero keeps everything dark
  function automatic logic [11:0] drive(input logic [1:0] d, input logic [15:0] v,
                                        input logic [3:0] dpm, input logic lzb);
    logic blank;
    blank = lzb && (d == 2'd3 ? v[15:12] == 4'h0 :
                    d == 2'd2 ? v[15:8] == 8'h0 :
                    d == 2'd1 ? v[15:4] == 12'h0 : 1'b0);
    drive = blank ? 12'hFFF : {~(4'b0001 << d), ~dpm[d], hex7(v[{d, 2'b00} +: 4])};
  endfunction
  logic [15:0]   r_data;
  logic [7:0]    r_ctrl;
  logic [15:0]   r_shadow;
  logic [3:0]    r_shadow_dp;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic          w_hit_data, w_hit_ctrl, w_load, w_adv;
  logic [1:0]    w_nxt_dig;
  logic [15:0]   w_nxt_v;
  logic [3:0]    w_nxt_dp;
  logic [11:0]   w_drive;
  always_comb begin
    w_hit_data = bus.iobus_addr == BASE_ADDR;
    w_hit_ctrl = bus.iobus_addr == BASE_ADDR + 32'd4;
    w_load = r_state == DISABLED || r_dig == 2'd3;
    w_adv = r_state == DISABLED || (r_state == GAP && r_cnt == GAP_LAST) ||
            (r_state == SHOW && r_cnt == SHOW_LAST && GAP_CYCLES == 0);
    w_nxt_dig = r_state == DISABLED ? 2'd0 : r_dig + 2'd1;
    w_nxt_v = w_load ? r_data : r_shadow;
    w_nxt_dp = w_load ? r_ctrl[7:4] : r_shadow_dp;
    w_drive = drive(w_nxt_dig, w_nxt_v, w_nxt_dp, r_ctrl[1]);
  end
  assign bus.iobus_rd_data = w_hit_data ? {16'h0, r_data} : w_hit_ctrl ? {24'h0, r_ctrl} : 32'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else if (bus.iobus_wr && w_hit_data) r_data <= bus.iobus_out[15:0];
    else if (bus.iobus_wr && w_hit_ctrl) r_ctrl <= {bus.iobus_out[7:4], 2'b00, bus.iobus_out[1:0]};
  // Shadow copies reload only when entering digit 0, so a frame never tears
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_shadow <= '0;
      r_shadow_dp <= '0;
      r_state <= DISABLED;
      r_cnt <= '0;
      r_dig <= '0;
      {an, segs} <= 12'hFFF;
    end else if (!r_ctrl[0]) begin
      r_state <= DISABLED;
      r_cnt <= '0;
      r_dig <= '0;
      {an, segs} <= 12'hFFF;
    end else if (w_adv) begin
      r_state <= SHOW;
      r_cnt <= '0;
      r_dig <= w_nxt_dig;
      {an, segs} <= w_drive;
      if (w_load) begin
        r_shadow <= r_data;
        r_shadow_dp <= r_ctrl[7:4];
      end
    end else if (r_state == SHOW && r_cnt == SHOW_LAST) begin
      r_state <= GAP;
      r_cnt <= '0;
      {an, segs} <= 12'hFFF;
    end else r_cnt <= r_cnt + CW'(1);
endmodule

// File: tb/tb_iobus_seg_display.sv
// tb_iobus_seg_display: directed checks of register access, scan order, blanking and tear-free update
module tb_iobus_seg_display;
  localparam logic [31:0] BASE = 32'h1100C00C;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] segs;
  logic [3:0] an;
  int n_cmp = 0;
  int n_bad = 0;
  iobus_seg_display_if bus();
  iobus_seg_display #(.BASE_ADDR(BASE), .REFRESH_DIV(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .segs(segs), .an(an));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.iobus_addr = a;
    bus.iobus_out = d;
    bus.iobus_wr = 1'b1;
    @(posedge clk);
    #1 bus.iobus_wr = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.iobus_addr = a;
    #1 chk(tag, bus.iobus_rd_data, exp);
  endtask
  task automatic slot(input string tag, input logic [11:0] exp);
    repeat (4) begin
      @(negedge clk);
      chk(tag, {20'h0, an, segs}, {20'h0, exp});
    end
    @(negedge clk);
    chk({tag, "_gap"}, {20'h0, an, segs}, 32'hFFF);
  endtask
  task automatic frame(input string tag, input logic [11:0] e0, e1, e2, e3);
    slot({tag, "_d0"}, e0);
    slot({tag, "_d1"}, e1);
    slot({tag, "_d2"}, e2);
    slot({tag, "_d3"}, e3);
  endtask
  task automatic start(input logic [15:0] d, input logic [7:0] c);
    wr_reg(BASE + 4, 32'h0);
    wr_reg(BASE, {16'h0, d});
    wr_reg(BASE + 4, {24'h0, c});
    @(negedge clk);
    chk("pre", {20'h0, an, segs}, 32'hFFF);
  endtask
  initial begin
    bus.iobus_addr = '0;
    bus.iobus_out = '0;
    bus.iobus_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_disp", {20'h0, an, segs}, 32'hFFF);
    rst_n = 1'b1;
    rd_chk("rst_data", BASE, 32'h0);
    rd_chk("rst_ctrl", BASE + 4, 32'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle", {20'h0, an, segs}, 32'hFFF);
    end
    wr_reg(BASE + 4, 32'h0000_002E);
    wr_reg(BASE, 32'hDEAD_12AF);
    wr_reg(BASE + 8, 32'h0000_5555);
    rd_chk("rd_ctrl", BASE + 4, 32'h22);
    rd_chk("rd_data", BASE, 32'h12AF);
    rd_chk("rd_other", BASE + 8, 32'h0);
    start(16'h12AF, 8'h01);
    frame("f1", 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
    frame("f2", 12'hE8E, 12'hD88, 12'hBA4, 12'h7F9);
    slot("mid_d0", 12'hE8E);
    fork
      wr_reg(BASE, 32'h3333);
      slot("mid_d1", 12'hD88);
    join
    slot("mid_d2", 12'hBA4);
    slot("mid_d3", 12'h7F9);
    slot("new_d0", 12'hEB0);
    slot("new_d1", 12'hDB0);
    slot("new_d2", 12'hBB0);
    fork
      slot("new_d3", 12'h7B0);
      begin
        repeat (5) @(negedge clk);
        bus.iobus_addr = BASE;
        bus.iobus_out = 32'h4444;
        bus.iobus_wr = 1'b1;
        @(posedge clk);
        #1 bus.iobus_wr = 1'b0;
      end
    join
    frame("bnd_old", 12'hEB0, 12'hDB0, 12'hBB0, 12'h7B0);
    frame("bnd_new", 12'hE99, 12'hD99, 12'hB99, 12'h799);
    @(negedge clk);
    chk("off_s1", {20'h0, an, segs}, 32'hE99);
    wr_reg(BASE + 4, 32'h0);
    @(negedge clk);
    chk("off_s3", {20'h0, an, segs}, 32'hE99);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("off_blank", {20'h0, an, segs}, 32'hFFF);
    end
    rd_chk("rd_data2", BASE, 32'h4444);
    start(16'h0005, 8'h03);
    frame("lzb5", 12'hE92, 12'hFFF, 12'hFFF, 12'hFFF);
    start(16'h0050, 8'h03);
    frame("lzb50", 12'hEC0, 12'hD92, 12'hFFF, 12'hFFF);
    start(16'h0050, 8'h01);
    frame("nolzb", 12'hEC0, 12'hD92, 12'hBC0, 12'h7C0);
    start(16'h12AF, 8'h21);
    frame("dp", 12'hE8E, 12'hD08, 12'hBA4, 12'h7F9);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst", {20'h0, an, segs}, 32'hE8E);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {20'h0, an, segs}, 32'hFFF);
    rd_chk("rst2_data", BASE, 32'h0);
    rd_chk("rst2_ctrl", BASE + 4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst", {20'h0, an, segs}, 32'hFFF);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
